// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card SPI arbiter.
package sd_pkg;

    typedef enum logic [2:0] {
        INIT_OWN,
        IDLE,
        GRANT_RD,
        GRANT_WR,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        SERVED_RD,
        SERVED_WR
    } served_t;

    localparam logic [47:0] SPI_IDLE_COMMAND      = 48'h0;
    localparam logic [9:0]  DEFAULT_TIMEOUT_EDGES = 10'd1000;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that saturates at rollover_val instead of wrapping.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable && (count_q != rollover_val)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/sd_spi_arbiter.sv
// Arbitrates the SPI shifter between the init, block-read and block-write
// controllers, with round-robin tie breaking and a per-grant sclk timeout.
module sd_spi_arbiter
    import sd_pkg::*;
#(
    parameter logic [9:0] TIMEOUT_EDGES = DEFAULT_TIMEOUT_EDGES
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        rising_edge_sclk,
    input  logic        init_status,
    input  logic [47:0] init_spi_command,
    input  logic        init_spi_CS,
    input  logic        init_spi_load_command,
    input  logic        init_spi_shift_command,
    input  logic        init_spi_shift_read,
    input  logic        rd_req,
    input  logic        rd_done,
    input  logic [47:0] rd_spi_command,
    input  logic        rd_spi_CS,
    input  logic        rd_spi_load_command,
    input  logic        rd_spi_shift_command,
    input  logic        rd_spi_shift_read,
    input  logic        wr_req,
    input  logic        wr_done,
    input  logic [47:0] wr_spi_command,
    input  logic        wr_spi_CS,
    input  logic        wr_spi_load_command,
    input  logic        wr_spi_shift_command,
    input  logic        wr_spi_shift_read,
    output logic [47:0] spi_command,
    output logic        spi_CS,
    output logic        spi_load_command,
    output logic        spi_shift_command,
    output logic        spi_shift_read,
    output logic        init_grant,
    output logic        rd_grant,
    output logic        wr_grant,
    output logic        timeout_err
);

    arb_state_t state_q, state_d;
    served_t    last_served_q, last_served_d;
    logic       timeout_err_q, timeout_err_d;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       timeout_hit;
    logic       granted;

    assign granted    = (state_q == GRANT_RD) || (state_q == GRANT_WR);
    assign cnt_enable = rising_edge_sclk && granted;

    flex_counter #(
        .NUM_CNT_BITS (10)
    ) u_timeout_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_enable),
        .rollover_val  (TIMEOUT_EDGES),
        .count_out     (),
        .rollover_flag (timeout_hit)
    );

    // A done pulse takes priority over a timeout seen in the same cycle.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        timeout_err_d = 1'b0;
        cnt_clear     = 1'b0;
        case (state_q)
            INIT_OWN: begin
                if (init_status) state_d = IDLE;
            end
            IDLE: begin
                if (rd_req && (!wr_req || (last_served_q == SERVED_WR))) begin
                    state_d       = GRANT_RD;
                    last_served_d = SERVED_RD;
                    cnt_clear     = 1'b1;
                end else if (wr_req) begin
                    state_d       = GRANT_WR;
                    last_served_d = SERVED_WR;
                    cnt_clear     = 1'b1;
                end
            end
            GRANT_RD: begin
                if (rd_done) begin
                    state_d = RELEASE;
                end else if (timeout_hit) begin
                    state_d       = RELEASE;
                    timeout_err_d = 1'b1;
                end
            end
            GRANT_WR: begin
                if (wr_done) begin
                    state_d = RELEASE;
                end else if (timeout_hit) begin
                    state_d       = RELEASE;
                    timeout_err_d = 1'b1;
                end
            end
            RELEASE:  state_d = IDLE;
            default:  state_d = INIT_OWN;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= INIT_OWN;
            last_served_q <= SERVED_WR;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign init_grant  = (state_q == INIT_OWN);
    assign rd_grant    = (state_q == GRANT_RD);
    assign wr_grant    = (state_q == GRANT_WR);
    assign timeout_err = timeout_err_q;

    always_comb begin
        spi_command       = SPI_IDLE_COMMAND;
        spi_CS            = 1'b1;
        spi_load_command  = 1'b0;
        spi_shift_command = 1'b0;
        spi_shift_read    = 1'b0;
        case (state_q)
            INIT_OWN: begin
                spi_command       = init_spi_command;
                spi_CS            = init_spi_CS;
                spi_load_command  = init_spi_load_command;
                spi_shift_command = init_spi_shift_command;
                spi_shift_read    = init_spi_shift_read;
            end
            GRANT_RD: begin
                spi_command       = rd_spi_command;
                spi_CS            = rd_spi_CS;
                spi_load_command  = rd_spi_load_command;
                spi_shift_command = rd_spi_shift_command;
                spi_shift_read    = rd_spi_shift_read;
            end
            GRANT_WR: begin
                spi_command       = wr_spi_command;
                spi_CS            = wr_spi_CS;
                spi_load_command  = wr_spi_load_command;
                spi_shift_command = wr_spi_shift_command;
                spi_shift_read    = wr_spi_shift_read;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Scoreboard bench for sd_spi_arbiter: transactions predicted at issue time,
// checked by a negedge monitor on every grant release.
module tb_sd_spi_arbiter;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        rising_edge_sclk = 1'b0;
    logic        init_status = 1'b0;
    logic [47:0] init_spi_command = '0;
    logic        init_spi_CS = 1'b0;
    logic        init_spi_load_command = 1'b0;
    logic        init_spi_shift_command = 1'b0;
    logic        init_spi_shift_read = 1'b0;
    logic        rd_req = 1'b0, rd_done = 1'b0;
    logic [47:0] rd_spi_command = '0;
    logic        rd_spi_CS = 1'b1, rd_spi_load_command = 1'b0;
    logic        rd_spi_shift_command = 1'b0, rd_spi_shift_read = 1'b0;
    logic        wr_req = 1'b0, wr_done = 1'b0;
    logic [47:0] wr_spi_command = '0;
    logic        wr_spi_CS = 1'b1, wr_spi_load_command = 1'b0;
    logic        wr_spi_shift_command = 1'b0, wr_spi_shift_read = 1'b0;
    logic [47:0] spi_command;
    logic        spi_CS, spi_load_command, spi_shift_command, spi_shift_read;
    logic        init_grant, rd_grant, wr_grant, timeout_err;

    always #5 clk = ~clk;

    sd_spi_arbiter dut (
        .clk                    (clk),
        .n_rst                  (n_rst),
        .rising_edge_sclk       (rising_edge_sclk),
        .init_status            (init_status),
        .init_spi_command       (init_spi_command),
        .init_spi_CS            (init_spi_CS),
        .init_spi_load_command  (init_spi_load_command),
        .init_spi_shift_command (init_spi_shift_command),
        .init_spi_shift_read    (init_spi_shift_read),
        .rd_req                 (rd_req),
        .rd_done                (rd_done),
        .rd_spi_command         (rd_spi_command),
        .rd_spi_CS              (rd_spi_CS),
        .rd_spi_load_command    (rd_spi_load_command),
        .rd_spi_shift_command   (rd_spi_shift_command),
        .rd_spi_shift_read      (rd_spi_shift_read),
        .wr_req                 (wr_req),
        .wr_done                (wr_done),
        .wr_spi_command         (wr_spi_command),
        .wr_spi_CS              (wr_spi_CS),
        .wr_spi_load_command    (wr_spi_load_command),
        .wr_spi_shift_command   (wr_spi_shift_command),
        .wr_spi_shift_read      (wr_spi_shift_read),
        .spi_command            (spi_command),
        .spi_CS                 (spi_CS),
        .spi_load_command       (spi_load_command),
        .spi_shift_command      (spi_shift_command),
        .spi_shift_read         (spi_shift_read),
        .init_grant             (init_grant),
        .rd_grant               (rd_grant),
        .wr_grant               (wr_grant),
        .timeout_err            (timeout_err)
    );

    typedef enum int {OWN_NONE, OWN_RD, OWN_WR} owner_t;
    typedef struct {
        owner_t owner;
        bit     by_timeout;
    } txn_t;

    txn_t   exp_q[$];
    int     total = 0;
    int     bad = 0;
    owner_t model_last = OWN_WR;
    bit     mon_en = 1'b0;
    owner_t prev_owner = OWN_NONE;
    owner_t mon_cur;
    txn_t   mon_txn;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic boundExpired(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // Ties go to whichever side did not win the previous grant.
    function automatic owner_t predictWinner(input int pat);
        if (pat == 3) return (model_last == OWN_WR) ? OWN_RD : OWN_WR;
        return (pat == 1) ? OWN_RD : OWN_WR;
    endfunction

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_owner = OWN_NONE;
        end else begin
            mon_cur = rd_grant ? OWN_RD : (wr_grant ? OWN_WR : OWN_NONE);
            checkOutput("grant_exclusive", 64'({rd_grant & wr_grant, init_grant}), 64'd0);
            case (mon_cur)
                OWN_RD: checkOutput("mux_rd",
                    64'({spi_command, spi_CS, spi_load_command, spi_shift_command, spi_shift_read}),
                    64'({rd_spi_command, rd_spi_CS, rd_spi_load_command, rd_spi_shift_command, rd_spi_shift_read}));
                OWN_WR: checkOutput("mux_wr",
                    64'({spi_command, spi_CS, spi_load_command, spi_shift_command, spi_shift_read}),
                    64'({wr_spi_command, wr_spi_CS, wr_spi_load_command, wr_spi_shift_command, wr_spi_shift_read}));
                default: checkOutput("mux_idle",
                    64'({spi_command, spi_CS, spi_load_command, spi_shift_command, spi_shift_read}),
                    64'({48'h0, 1'b1, 3'b000}));
            endcase
            if (prev_owner != OWN_NONE && mon_cur == OWN_NONE) begin
                if (exp_q.size() == 0) begin
                    boundExpired("unexpected_release");
                end else begin
                    mon_txn = exp_q.pop_front();
                    checkOutput("release_owner", 64'(prev_owner), 64'(mon_txn.owner));
                    checkOutput("release_timeout_err", 64'(timeout_err), 64'(mon_txn.by_timeout));
                end
            end else begin
                checkOutput("stray_timeout_err", 64'(timeout_err), 64'd0);
            end
            prev_owner = mon_cur;
        end
    end

    task automatic waitGrant(input owner_t who, input string name);
        int n = 0;
        while (!((who == OWN_RD && rd_grant) || (who == OWN_WR && wr_grant)) && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("[TB] FAIL %s: grant never seen within 40 cycles", name);
        end
    endtask

    task automatic waitRelease(input int limit, input string name);
        int n = 0;
        while ((rd_grant || wr_grant) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) boundExpired(name);
    endtask

    task automatic pulseDone(input owner_t who);
        if (who == OWN_RD) rd_done = 1'b1; else wr_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
        wr_done = 1'b0;
    endtask

    task automatic randomizeDrive();
        rd_spi_command       = 48'({$urandom, $urandom});
        rd_spi_CS            = 1'($urandom);
        rd_spi_load_command  = 1'($urandom);
        rd_spi_shift_command = 1'($urandom);
        rd_spi_shift_read    = 1'($urandom);
        wr_spi_command       = 48'({$urandom, $urandom});
        wr_spi_CS            = 1'($urandom);
        wr_spi_load_command  = 1'($urandom);
        wr_spi_shift_command = 1'($urandom);
        wr_spi_shift_read    = 1'($urandom);
    endtask

    // pat: 1 = read only, 2 = write only, 3 = both requesting.
    task automatic applyStimulus(input int pat, input bit timeout_case);
        owner_t win;
        txn_t   t;
        win          = predictWinner(pat);
        model_last   = win;
        t.owner      = win;
        t.by_timeout = timeout_case;
        exp_q.push_back(t);
        randomizeDrive();
        rd_req = (pat & 1) != 0;
        wr_req = (pat & 2) != 0;
        waitGrant(win, "grant_wait");
        @(posedge clk); #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        if (timeout_case) begin
            rising_edge_sclk = 1'b1;
            waitRelease(1100, "timeout_release_wait");
            rising_edge_sclk = 1'b0;
        end else begin
            repeat ($urandom_range(0, 6)) begin
                rising_edge_sclk = 1'($urandom);
                @(posedge clk); #1;
            end
            rising_edge_sclk = 1'b0;
            if ($urandom_range(0, 1) == 1) pulseDone((win == OWN_RD) ? OWN_WR : OWN_RD);
            pulseDone(win);
            waitRelease(10, "done_release_wait");
        end
        @(posedge clk); #1;
    endtask

    task automatic heldTriple();
        txn_t   t;
        owner_t order[3];
        for (int i = 0; i < 3; i++) begin
            order[i]     = predictWinner(3);
            model_last   = order[i];
            t.owner      = order[i];
            t.by_timeout = 1'b0;
            exp_q.push_back(t);
        end
        randomizeDrive();
        rd_req = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitGrant(order[i], "held_grant_wait");
            @(posedge clk); #1;
            if (i == 2) begin
                rd_req = 1'b0;
                wr_req = 1'b0;
            end
            pulseDone(order[i]);
            waitRelease(10, "held_release_wait");
        end
        @(posedge clk); #1;
    endtask

    // Done lands in the cycle where the count has just reached the limit.
    task automatic coincidentDone();
        txn_t t;
        t.owner      = OWN_RD;
        t.by_timeout = 1'b0;
        model_last   = OWN_RD;
        exp_q.push_back(t);
        randomizeDrive();
        rd_req = 1'b1;
        waitGrant(OWN_RD, "coincident_grant_wait");
        @(posedge clk); #1;
        rd_req = 1'b0;
        rising_edge_sclk = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        rising_edge_sclk = 1'b0;
        pulseDone(OWN_RD);
        waitRelease(10, "coincident_release_wait");
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        init_spi_command       = 48'h400000000095;
        init_spi_CS            = 1'b0;
        init_spi_load_command  = 1'b1;
        init_spi_shift_command = 1'b0;
        init_spi_shift_read    = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        checkOutput("reset_grants", 64'({init_grant, rd_grant, wr_grant, timeout_err}), 64'(4'b1000));
        checkOutput("reset_init_mux",
            64'({spi_command, spi_CS, spi_load_command, spi_shift_command, spi_shift_read}),
            64'({48'h400000000095, 1'b0, 1'b1, 1'b0, 1'b1}));
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        init_spi_command = 48'h0000_1234_ABCD;
        init_spi_CS      = 1'b1;
        @(negedge clk);
        checkOutput("init_hold_grant", 64'({init_grant, rd_grant, wr_grant}), 64'(3'b100));
        checkOutput("init_follow_cmd", 64'(spi_command), 64'h0000_1234_ABCD);
        @(posedge clk); #1;
        init_status = 1'b1;
        @(negedge clk);
        checkOutput("init_not_left_early", 64'(init_grant), 64'd1);
        @(negedge clk);
        checkOutput("idle_grants", 64'({init_grant, rd_grant, wr_grant}), 64'd0);
        checkOutput("idle_cs", 64'(spi_CS), 64'd1);
        @(posedge clk); #1;
        init_status = 1'b0;
        mon_en = 1'b1;

        heldTriple();
        coincidentDone();
        applyStimulus(2, 1'b1);
        for (int i = 0; i < 25; i++) applyStimulus($urandom_range(1, 3), 1'b0);

        init_spi_command = 48'h4800_0001_AA87;
        init_spi_CS      = 1'b0;
        wr_req = 1'b1;
        waitGrant(OWN_WR, "reset_grant_wait");
        @(posedge clk); #1;
        wr_req = 1'b0;
        mon_en = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midgrant_reset_grants", 64'({init_grant, rd_grant, wr_grant, timeout_err}), 64'(4'b1000));
        checkOutput("midgrant_reset_cs", 64'(spi_CS), 64'd0);
        checkOutput("midgrant_reset_cmd", 64'(spi_command), 64'h4800_0001_AA87);
        @(posedge clk); #1;
        init_status = 1'b1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        init_status = 1'b0;
        model_last = OWN_WR;
        mon_en = 1'b1;
        applyStimulus(3, 1'b0);
        applyStimulus(3, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) boundExpired("scoreboard_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
